// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding and default
// frame-format constants used by both the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_t;

  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_STOP_BITS    = 1;
  localparam int DEF_OVERSAMPLING = 16;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input,
// with a configurable reset value for the idle level of the line.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling, LSB-first data,
// held-byte handshake with sticky overrun and frame-error pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int STOP_BITS    = DEF_STOP_BITS,
  parameter int OVERSAMPLING = DEF_OVERSAMPLING
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 ack_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err_out,
  output logic                 overrun_out,
  output logic                 busy_out
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STP = BW'(STOP_BITS - 1);

  uart_state_t          state;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_err;
  logic                 rx_s;
  logic                 stop_bad;

  uart_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_in(clk_in),
    .rst   (rst),
    .d     (rx),
    .q     (rx_s)
  );

  // Accumulates a low sample across all stop bits of the frame.
  assign stop_bad = stop_err | ~rx_s;
  assign busy_out = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      stop_err      <= 1'b0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      frame_err_out <= 1'b0;
      if (ack_in && valid_out)
        valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              stop_err <= 1'b0;
              state    <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            if (bit_cnt == LAST_STP) begin
              bit_cnt <= '0;
              if (stop_bad) begin
                frame_err_out <= 1'b1;
                state         <= WAIT_IDLE;
              end else begin
                // A same-cycle ack retires the old byte, so no overrun.
                data_out  <= shreg;
                valid_out <= 1'b1;
                if (valid_out && !ack_in)
                  overrun_out <= 1'b1;
                state <= IDLE;
              end
            end else begin
              bit_cnt  <= bit_cnt + BW'(1);
              stop_err <= stop_bad;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, directed corner
// sequences and random frames against a frame-level reference model.
module tb_uart_rx;

  localparam int DB = 8;
  localparam int SB = 1;
  localparam int OS = 16;
  localparam int LAT = 2 + OS / 2 + (DB + SB) * OS + 1;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          rx;
  logic          ack_in;
  logic [DB-1:0] data_out;
  logic          valid_out;
  logic          frame_err_out;
  logic          overrun_out;
  logic          busy_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int rise_cyc = -1;
  int fe_cnt = 0;
  bit fe_long = 1'b0;
  bit prev_v = 1'b0;
  bit prev_fe = 1'b0;

  logic [DB-1:0] m_data;
  bit            m_valid;
  bit            m_ovr;
  int            m_fe;

  uart_rx #(
    .DATA_BITS   (DB),
    .STOP_BITS   (SB),
    .OVERSAMPLING(OS)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .rx           (rx),
    .ack_in       (ack_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .frame_err_out(frame_err_out),
    .overrun_out  (overrun_out),
    .busy_out     (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (valid_out && !prev_v) rise_cyc = cyc;
    if (frame_err_out) begin
      if (prev_fe) fe_long = 1'b1;
      else fe_cnt++;
    end
    prev_v  = valid_out;
    prev_fe = frame_err_out;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack_before;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_fe;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    idle(2);
  endtask

  task automatic ack_pulse();
    ack_in = 1'b1;
    idle(1);
    ack_in = 1'b0;
  endtask

  // Called just after a falling clock edge; leaves rx at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    last_fall = cyc;
    rx = 1'b0;
    idle(OS);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      idle(OS);
    end
    rx = stop;
    idle(OS * SB);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"}, int'(data_out), 0);
    check({tag, "_valid"}, int'(valid_out), 0);
    check({tag, "_fe"}, int'(frame_err_out), 0);
    check({tag, "_ovr"}, int'(overrun_out), 0);
    check({tag, "_busy"}, int'(busy_out), 0);
  endtask

  initial begin
    int fe0;
    int t0;
    logic [7:0] rd;
    logic rs;
    logic ra;

    rst = 1'b1;
    rx = 1'b1;
    ack_in = 1'b0;
    idle(3);
    check_reset_vals("reset");
    rst = 1'b0;
    idle(3);

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 0};

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].ack_before) ack_pulse();
      fe0 = fe_cnt;
      rise_cyc = -1;
      send_frame(vecs[v].data, vecs[v].stop);
      rx = 1'b1;
      idle(20);
      check($sformatf("vec%0d_data", v), int'(data_out),
            int'(vecs[v].exp_data));
      check($sformatf("vec%0d_valid", v), int'(valid_out),
            int'(vecs[v].exp_valid));
      check($sformatf("vec%0d_ovr", v), int'(overrun_out),
            int'(vecs[v].exp_ovr));
      check($sformatf("vec%0d_fe", v), fe_cnt - fe0, vecs[v].exp_fe);
      if (v == 0)
        check("latency", rise_cyc - last_fall, LAT);
    end

    ack_pulse();
    idle(2);
    check("ack_valid", int'(valid_out), 0);
    check("ack_ovr", int'(overrun_out), 1);
    check("ack_data", int'(data_out), 'h5A);

    // Short low glitch on an idle line.
    do_reset();
    fe0 = fe_cnt;
    rx = 1'b0;
    idle(5);
    check("glitch_busy_hi", int'(busy_out), 1);
    rx = 1'b1;
    idle(20);
    check("glitch_busy_lo", int'(busy_out), 0);
    check("glitch_valid", int'(valid_out), 0);
    check("glitch_fe", fe_cnt - fe0, 0);

    // Bad stop bit followed by a held-low line.
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    idle(100);
    check("brk_fe", fe_cnt - fe0, 1);
    check("brk_valid", int'(valid_out), 0);
    check("brk_busy", int'(busy_out), 1);
    rx = 1'b1;
    idle(20);
    check("brk_busy_lo", int'(busy_out), 0);
    send_frame(8'h5A, 1'b1);
    rx = 1'b1;
    idle(20);
    check("brk_next_data", int'(data_out), 'h5A);
    check("brk_next_valid", int'(valid_out), 1);

    // Ack on the exact completion cycle of a second frame.
    do_reset();
    send_frame(8'h11, 1'b1);
    rx = 1'b1;
    idle(20);
    t0 = cyc;
    fork
      send_frame(8'h77, 1'b1);
      begin
        idle(LAT - 1);
        ack_in = 1'b1;
        idle(1);
        ack_in = 1'b0;
      end
    join
    rx = 1'b1;
    idle(20);
    check("ackc_valid", int'(valid_out), 1);
    check("ackc_data", int'(data_out), 'h77);
    check("ackc_ovr", int'(overrun_out), 0);
    check("ackc_start", last_fall, t0);

    // Reset in the middle of a frame, with prior state non-zero.
    do_reset();
    send_frame(8'h11, 1'b1);
    rx = 1'b1;
    idle(20);
    send_frame(8'h22, 1'b1);
    rx = 1'b1;
    idle(20);
    check("pre_rst_ovr", int'(overrun_out), 1);
    fe0 = fe_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(OS * 4 + OS / 2);
        rst = 1'b1;
        idle(1);
        check_reset_vals("midrst");
        rst = 1'b0;
      end
    join
    rx = 1'b1;
    idle(20);
    check("midrst_valid_after", int'(valid_out), 0);
    check("midrst_fe_after", fe_cnt - fe0, 0);
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    idle(20);
    check("midrst_next_data", int'(data_out), 'h81);
    check("midrst_next_valid", int'(valid_out), 1);
    check("midrst_next_ovr", int'(overrun_out), 0);

    // Random frames against the frame-level reference model.
    do_reset();
    m_fe = fe_cnt;
    for (int n = 0; n < 12; n++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      ra = 1'($urandom_range(0, 1));
      if (ra) begin
        ack_pulse();
        m_valid = 1'b0;
      end
      send_frame(rd, rs);
      rx = 1'b1;
      if (rs) begin
        if (m_valid) m_ovr = 1'b1;
        m_data  = rd;
        m_valid = 1'b1;
      end else begin
        m_fe++;
      end
      idle(10 + $urandom_range(0, 20));
      check($sformatf("rnd%0d_data", n), int'(data_out), int'(m_data));
      check($sformatf("rnd%0d_valid", n), int'(valid_out), int'(m_valid));
      check($sformatf("rnd%0d_ovr", n), int'(overrun_out), int'(m_ovr));
      check($sformatf("rnd%0d_fe", n), fe_cnt, m_fe);
    end

    check("fe_one_cycle", int'(fe_long), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, LSB first.
REQ-002 Parameter STOP_BITS, default 1, number of stop bits, 1 or 2.
REQ-003 Parameter OVERSAMPLING, default 16, clk_in cycles per bit; must be even and ≥4.
REQ-004 clk_in  input  1  the only clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 rx  input  1  asynchronous serial line; idle high.
REQ-007 ack_in  input  1  consumer accepts the held byte.
REQ-008 data_out  output  DATA_BITS  last received byte.
REQ-009 valid_out  output  1  data_out holds an unaccepted byte.
REQ-010 frame_err_out  output  1  one-cycle pulse for a stop bit sampled low.
REQ-011 overrun_out  output  1  sticky flag: a byte completed while valid_out was high.
REQ-012 busy_out  output  1  high in every state except IDLE.

Function
REQ-013 Synchronisation: rx passes through a 2-flop synchroniser (preset high) to give rx_s, and all decisions use rx_s.
REQ-014 States: IDLE, START, DATA, STOP, WAIT_IDLE, with a cycle counter clk_cnt and a bit counter bit_cnt.
REQ-015 IDLE: rx_s==0 -> START with clk_cnt=0.
REQ-016 START: at clk_cnt==OVERSAMPLING/2-1, rx_s==0 -> DATA with clk_cnt=0 and bit_cnt=0; rx_s==1 -> IDLE as a glitch, with no output change.
REQ-017 DATA: at clk_cnt==OVERSAMPLING-1, shift rx_s into the MSB of the shift register, reset clk_cnt, and increment bit_cnt; after DATA_BITS samples -> STOP with bit_cnt=0.
REQ-018 STOP: each stop bit is sampled at clk_cnt==OVERSAMPLING-1, and the state exits right after the last stop sample with no wait for the bit end.
REQ-019 STOP, all stop samples high: the next cycle data_out takes the shift register, valid_out=1 -> IDLE.
REQ-020 STOP, any stop sample low: the next cycle frame_err_out=1 for one cycle, data_out and valid_out are unchanged -> WAIT_IDLE.
REQ-021 WAIT_IDLE (break/line-low handling): stay until rx_s==1, then -> IDLE.
REQ-022 Handshake: valid_out clears the cycle after ack_in==1 while valid_out==1; ack_in with valid_out==0 is ignored.
REQ-023 Simultaneous completion and ack_in: the new byte wins, valid_out stays 1, overrun_out is not set.
REQ-024 Completion with valid_out==1 and no ack_in: data_out is overwritten, valid_out stays 1, overrun_out=1.
REQ-025 overrun_out clears only on reset.
REQ-026 Latency: from the first IDLE cycle with rx_s==0 to valid_out high = OVERSAMPLING/2 + (DATA_BITS+STOP_BITS)*OVERSAMPLING + 1 cycles, plus 2 synchroniser cycles from rx.
REQ-027 Widths: clk_cnt is $clog2(OVERSAMPLING) bits and bit_cnt is $clog2(DATA_BITS+1) bits, with no wrap before the compare points.

Reset
REQ-028 With rst==1 at a clk_in edge: state=IDLE, synchroniser flops=1, data_out=0, valid_out=0, frame_err_out=0, overrun_out=0, busy_out=0, counters=0.
REQ-029 Reset mid-frame aborts the frame with no valid_out or frame_err_out, and reception restarts on the next falling edge after rst deasserts.

Structure
REQ-030 Package uart_pkg holds the state encoding (IDLE..WAIT_IDLE) and the default DATA_BITS, STOP_BITS and OVERSAMPLING constants shared with the transmitter.
REQ-031 The synchroniser is the sub-module uart_sync (2 flops, parameterised reset value), instantiated once.

Verification
REQ-032 Defaults, rx frame 0xA5 at 16 cycles/bit, ack_in held low: data_out=0xA5, valid_out=1 exactly 153 cycles after the first rx_s low, and frame_err_out never pulses.
REQ-033 A 5-cycle low glitch on idle rx: START returns to IDLE, busy_out falls, and valid_out and frame_err_out stay 0.
REQ-034 Frame 0x3C with the stop bit driven low, then rx held low 100 cycles: frame_err_out one-cycle pulse, valid_out=0, state WAIT_IDLE until rx high, then the next frame 0x5A is received correctly.
REQ-035 Two back-to-back frames 0x11 then 0x22 with no ack: data_out=0x22, valid_out=1, overrun_out=1; an ack_in pulse then clears valid_out only.
REQ-036 ack_in asserted on the exact completion cycle of a second frame: valid_out stays 1, data_out=new byte, overrun_out=0.
REQ-037 rst pulsed at the 4th data bit of 0xFF: all outputs return to reset values, and a following frame 0x81 is received correctly.
